// File: rtl/nibble_pack_pkg.sv
// Shared constants, sizing helpers and lane-state type for the nibble packer.
// The optional output parity port is enabled by defining NIBBLE_PACK_PARITY_EN.
package nibble_pack_pkg;

    function automatic int calc_npn(input int data_w, input int nib_w);
        return data_w / nib_w;
    endfunction

    // A single-nibble word still needs one select bit to keep port widths legal.
    function automatic int calc_sel_w(input int npn);
        return (npn > 1) ? $clog2(npn) : 1;
    endfunction

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NIB_W  = 4;
    localparam int DEF_SEL_W  = calc_sel_w(calc_npn(DEF_DATA_W, DEF_NIB_W));

    typedef struct packed {
        logic [DEF_SEL_W-1:0]  cnt;
        logic [DEF_DATA_W-1:0] acc;
    } lane_state_t;

endpackage

// File: rtl/nibble_pack_lane.sv
// One packing lane: nibble mux, fill counter, accumulator and held output word.
// Optional parity output exists only when NIBBLE_PACK_PARITY_EN is defined.
module nibble_pack_lane
    import nibble_pack_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NIB_W = 4,
    localparam int NPN = calc_npn(DATA_W, NIB_W),
    localparam int SEL_W = calc_sel_w(NPN)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              accept,
    input  logic              flush_go,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [SEL_W-1:0]  sel_a_idx,
    input  logic [SEL_W-1:0]  sel_b_idx,
    input  logic              sel,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] word
`ifdef NIBBLE_PACK_PARITY_EN
    ,
    output logic              parity
`endif
);

    typedef struct packed {
        logic [SEL_W-1:0]  cnt;
        logic [DATA_W-1:0] acc;
    } state_t;

    state_t           cur;
    state_t           filled;
    state_t           nxt;
    logic             emit;
    logic [NIB_W-1:0] nib;

    // Indices past the last nibble fall back to nibble 0.
    always_comb begin
        nib = data_a[NIB_W-1:0];
        if (sel) begin
            nib = data_b[NIB_W-1:0];
            if (int'(sel_b_idx) < NPN) begin
                nib = data_b[int'(sel_b_idx)*NIB_W +: NIB_W];
            end
        end else if (int'(sel_a_idx) < NPN) begin
            nib = data_a[int'(sel_a_idx)*NIB_W +: NIB_W];
        end
    end

    // The beat is packed before flush looks at the count.
    always_comb begin
        filled = cur;
        emit   = 1'b0;
        if (accept) begin
            filled.acc[int'(cur.cnt)*NIB_W +: NIB_W] = nib;
            if (int'(cur.cnt) == NPN - 1) begin
                emit = 1'b1;
            end else begin
                filled.cnt = cur.cnt + 1'b1;
            end
        end
        if (flush_go && (filled.cnt != '0)) begin
            emit = 1'b1;
        end
        nxt = emit ? '0 : filled;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cur       <= '0;
            out_valid <= 1'b0;
            word      <= '0;
        end else begin
            cur <= nxt;
            if (emit) begin
                out_valid <= 1'b1;
                word      <= filled.acc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef NIBBLE_PACK_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            parity <= 1'b0;
        end else if (emit) begin
            parity <= ^filled.acc;
        end
    end
`endif

endmodule

// File: rtl/nibble_pack_sel.sv
// Top of the multi-lane nibble packer: shared input handshake and lane slicing.
// Define NIBBLE_PACK_PARITY_EN to add the per-lane out_parity port.
module nibble_pack_sel
    import nibble_pack_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int NIB_W = 4,
    localparam int SEL_W = calc_sel_w(calc_npn(DATA_W, NIB_W))
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        data_a,
    input  logic [DATA_W-1:0]        data_b,
    input  logic [NUM_CH*SEL_W-1:0]  sel_a,
    input  logic [NUM_CH*SEL_W-1:0]  sel_b,
    input  logic [NUM_CH-1:0]        sel,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] nibble_out
`ifdef NIBBLE_PACK_PARITY_EN
    ,
    output logic [NUM_CH-1:0]        out_parity
`endif
);

    logic accept;
    logic flush_go;

    // Any lane still holding an unread word stalls every lane, keeping counts aligned.
    assign in_ready = &(~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign flush_go = flush & in_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        nibble_pack_lane #(
            .DATA_W(DATA_W),
            .NIB_W (NIB_W)
        ) u_lane (
            .clk      (clk),
            .reset_L  (reset_L),
            .accept   (accept),
            .flush_go (flush_go),
            .data_a   (data_a),
            .data_b   (data_b),
            .sel_a_idx(sel_a[i*SEL_W +: SEL_W]),
            .sel_b_idx(sel_b[i*SEL_W +: SEL_W]),
            .sel      (sel[i]),
            .out_ready(out_ready[i]),
            .out_valid(out_valid[i]),
            .word     (nibble_out[i*DATA_W +: DATA_W])
`ifdef NIBBLE_PACK_PARITY_EN
            ,
            .parity   (out_parity[i])
`endif
        );
    end

endmodule

// File: tb/tb_nibble_pack_sel.sv
// Self-checking bench for nibble_pack_sel: directed scenarios plus randomized traffic
// against a queue-based reference model. Parity is checked when NIBBLE_PACK_PARITY_EN is set.
module tb_nibble_pack_sel;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int NIB_W  = 4;
    localparam int NPN    = 8;
    localparam int SEL_W  = 3;

    logic                     clk;
    logic                     reset_L;
    logic                     in_valid;
    logic                     in_ready;
    logic                     flush;
    logic [DATA_W-1:0]        data_a;
    logic [DATA_W-1:0]        data_b;
    logic [NUM_CH*SEL_W-1:0]  sel_a;
    logic [NUM_CH*SEL_W-1:0]  sel_b;
    logic [NUM_CH-1:0]        sel;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;
    logic [NUM_CH*DATA_W-1:0] nibble_out;
`ifdef NIBBLE_PACK_PARITY_EN
    logic [NUM_CH-1:0]        out_parity;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: each lane is a queue of collected nibbles plus the held output word.
    logic [NIB_W-1:0]  m_q[NUM_CH][$];
    logic [DATA_W-1:0] m_word[NUM_CH];
    bit                m_valid[NUM_CH];

    nibble_pack_sel #(
        .NUM_CH(NUM_CH),
        .DATA_W(DATA_W),
        .NIB_W (NIB_W)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .data_a    (data_a),
        .data_b    (data_b),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .nibble_out(nibble_out)
`ifdef NIBBLE_PACK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_ready();
        bit r = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_valid[i] && !out_ready[i]) r = 1'b0;
        end
        return r;
    endfunction

    task automatic model_edge();
        bit                rdy;
        bit                emit;
        int                idx;
        logic [DATA_W-1:0] shifted;
        logic [DATA_W-1:0] w;
        rdy = m_ready();
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset_L) begin
                m_q[i].delete();
                m_word[i]  = '0;
                m_valid[i] = 1'b0;
            end else begin
                emit = 1'b0;
                if (in_valid && rdy) begin
                    idx     = sel[i] ? int'(sel_b[i*SEL_W +: SEL_W]) : int'(sel_a[i*SEL_W +: SEL_W]);
                    shifted = (sel[i] ? data_b : data_a) >> (idx * NIB_W);
                    m_q[i].push_back(shifted[NIB_W-1:0]);
                    if (m_q[i].size() == NPN) emit = 1'b1;
                end
                if (flush && rdy && m_q[i].size() > 0) emit = 1'b1;
                if (emit) begin
                    w = '0;
                    for (int k = 0; k < m_q[i].size(); k++) begin
                        w = w | (DATA_W'(m_q[i][k]) << (k * NIB_W));
                    end
                    m_word[i]  = w;
                    m_valid[i] = 1'b1;
                    m_q[i].delete();
                end else if (out_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic randomize_sels();
        data_a = $urandom;
        data_b = $urandom;
        sel_a  = NUM_CH*SEL_W'($urandom);
        sel_b  = NUM_CH*SEL_W'($urandom);
        sel    = NUM_CH'($urandom);
    endtask

    task automatic test_reset();
        reset_L   = 1'b0;
        in_valid  = 1'b1;
        flush     = 1'b0;
        out_ready = '1;
        randomize_sels();
        cycle();
        cycle();
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got %h expected 0", out_valid);
        end
        checks++;
        if (nibble_out !== '0) begin
            errors++;
            $display("[TB] FAIL reset_nibble_out got %h expected 0", nibble_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got %b expected 1", in_ready);
        end
        reset_L  = 1'b1;
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_pack_a();
        out_ready = '1;
        in_valid  = 1'b1;
        randomize_sels();
        sel    = '0;
        data_a = 32'h76543210;
        for (int k = 0; k < NPN; k++) begin
            sel_a[0 +: SEL_W] = SEL_W'(k);
            cycle();
        end
        checks++;
        if (out_valid[0] !== 1'b1 || nibble_out[0 +: DATA_W] !== 32'h76543210) begin
            errors++;
            $display("[TB] FAIL pack_a got v=%b w=%h expected v=1 w=76543210", out_valid[0], nibble_out[0 +: DATA_W]);
        end
        for (int i = 1; i < NUM_CH; i++) begin
            checks++;
            if (out_valid[i] !== m_valid[i] || nibble_out[i*DATA_W +: DATA_W] !== m_word[i]) begin
                errors++;
                $display("[TB] FAIL pack_a_lane%0d got v=%b w=%h expected v=%b w=%h", i, out_valid[i],
                         nibble_out[i*DATA_W +: DATA_W], m_valid[i], m_word[i]);
            end
        end
        in_valid = 1'b0;
        cycle();
        checks++;
        if (out_valid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pack_a_one_cycle got %b expected 0", out_valid[0]);
        end
    endtask

    task automatic test_pack_b();
        out_ready = '1;
        in_valid  = 1'b1;
        randomize_sels();
        sel[2] = 1'b1;
        data_b = 32'hFEDCBA98;
        for (int k = 0; k < NPN; k++) begin
            sel_b[2*SEL_W +: SEL_W] = SEL_W'(NPN - 1 - k);
            cycle();
        end
        checks++;
        if (out_valid[2] !== 1'b1 || nibble_out[2*DATA_W +: DATA_W] !== 32'h89ABCDEF) begin
            errors++;
            $display("[TB] FAIL pack_b got v=%b w=%h expected v=1 w=89abcdef", out_valid[2], nibble_out[2*DATA_W +: DATA_W]);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        out_ready = 4'b1101;
        in_valid  = 1'b1;
        for (int k = 0; k < NPN; k++) begin
            randomize_sels();
            cycle();
        end
        held = m_word[1];
        for (int c = 0; c < 10; c++) begin
            randomize_sels();
            cycle();
            checks++;
            if (in_ready !== 1'b0 || out_valid[1] !== 1'b1 || nibble_out[DATA_W +: DATA_W] !== held) begin
                errors++;
                $display("[TB] FAIL backpressure_hold cyc %0d got rdy=%b v=%b w=%h expected rdy=0 v=1 w=%h", c, in_ready,
                         out_valid[1], nibble_out[DATA_W +: DATA_W], held);
            end
        end
        out_ready = '1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL backpressure_release got %b expected 1", in_ready);
        end
        for (int k = 0; k < NPN; k++) begin
            randomize_sels();
            cycle();
        end
        checks++;
        if (out_valid[1] !== 1'b1 || nibble_out[DATA_W +: DATA_W] !== m_word[1]) begin
            errors++;
            $display("[TB] FAIL backpressure_second got v=%b w=%h expected v=1 w=%h", out_valid[1],
                     nibble_out[DATA_W +: DATA_W], m_word[1]);
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_flush();
        out_ready = '1;
        in_valid  = 1'b1;
        randomize_sels();
        sel    = '0;
        data_a = 32'hFEDCBA98;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NUM_CH; i++) sel_a[i*SEL_W +: SEL_W] = SEL_W'(k + 2);
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        cycle();
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (out_valid[i] !== 1'b1 || nibble_out[i*DATA_W +: DATA_W] !== 32'h00000CBA) begin
                errors++;
                $display("[TB] FAIL flush_partial lane%0d got v=%b w=%h expected v=1 w=00000cba", i, out_valid[i],
                         nibble_out[i*DATA_W +: DATA_W]);
            end
        end
        cycle();
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("[TB] FAIL flush_empty got %h expected 0", out_valid);
        end
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = '1;
        in_valid  = 1'b1;
        for (int k = 0; k < 2*NPN; k++) begin
            randomize_sels();
            cycle();
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (out_valid[i] !== m_valid[i] || nibble_out[i*DATA_W +: DATA_W] !== m_word[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b beat %0d lane%0d got v=%b w=%h expected v=%b w=%h", k, i, out_valid[i],
                             nibble_out[i*DATA_W +: DATA_W], m_valid[i], m_word[i]);
                end
            end
        end
        // Word completes via single-beat flush while the previous word is being consumed.
        randomize_sels();
        flush = 1'b1;
        cycle();
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (out_valid[i] !== 1'b1 || nibble_out[i*DATA_W + NIB_W +: DATA_W - NIB_W] !== '0 ||
                nibble_out[i*DATA_W +: DATA_W] !== m_word[i]) begin
                errors++;
                $display("[TB] FAIL b2b_no_bubble lane%0d got v=%b w=%h expected v=1 w=%h", i, out_valid[i],
                         nibble_out[i*DATA_W +: DATA_W], m_word[i]);
            end
        end
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            randomize_sels();
            cycle();
        end
        in_valid = 1'b0;
        reset_L  = 1'b0;
        cycle();
        reset_L  = 1'b1;
        in_valid = 1'b1;
        randomize_sels();
        sel    = '0;
        data_a = 32'h76543210;
        for (int k = 0; k < NPN; k++) begin
            for (int i = 0; i < NUM_CH; i++) sel_a[i*SEL_W +: SEL_W] = SEL_W'(k);
            cycle();
        end
        for (int i = 0; i < NUM_CH; i++) begin
            checks++;
            if (out_valid[i] !== 1'b1 || nibble_out[i*DATA_W +: DATA_W] !== 32'h76543210) begin
                errors++;
                $display("[TB] FAIL reset_mid_fill lane%0d got v=%b w=%h expected v=1 w=76543210", i, out_valid[i],
                         nibble_out[i*DATA_W +: DATA_W]);
            end
        end
        in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            randomize_sels();
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = NUM_CH'($urandom) | NUM_CH'($urandom);
            reset_L   = ($urandom_range(0, 99) != 0);
            cycle();
            checks++;
            if (in_ready !== m_ready()) begin
                errors++;
                $display("[TB] FAIL random_in_ready cyc %0d got %b expected %b", c, in_ready, m_ready());
            end
            for (int i = 0; i < NUM_CH; i++) begin
                checks++;
                if (out_valid[i] !== m_valid[i] || nibble_out[i*DATA_W +: DATA_W] !== m_word[i]) begin
                    errors++;
                    $display("[TB] FAIL random cyc %0d lane%0d got v=%b w=%h expected v=%b w=%h", c, i, out_valid[i],
                             nibble_out[i*DATA_W +: DATA_W], m_valid[i], m_word[i]);
                end
`ifdef NIBBLE_PACK_PARITY_EN
                checks++;
                if (out_parity[i] !== (^m_word[i])) begin
                    errors++;
                    $display("[TB] FAIL random_parity cyc %0d lane%0d got %b expected %b", c, i, out_parity[i], ^m_word[i]);
                end
`endif
            end
        end
        reset_L  = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        reset_L   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = '1;
        data_a    = '0;
        data_b    = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel       = '0;
        test_reset();
        test_pack_a();
        test_pack_b();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
